// File: rtl/ads8528_responder.sv
// rtl/ads8528_responder.sv - ADC-side model of the ADS8528 parallel interface.
// Conversion timing, sample capture, RD readback and two-word config writes.
module ads8528_responder #(
    parameter int CONV_CYCLES = 33,
    parameter int DATA_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  convst_A,
    input  logic                  convst_B,
    input  logic                  convst_C,
    input  logic                  convst_D,
    input  logic                  CS,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     db_in,
    output logic [DATA_W-1:0]     db_out,
    output logic                  db_oe,
    output logic                  busy,
    input  logic [8*DATA_W-1:0]   sample_bus,
    output logic [31:0]           config_reg,
    output logic [15:0]           frame_count
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state, next_state;
    logic [7:0]        cnt, cnt_d;
    logic [3:0]        mask, mask_d;
    logic              done;
    logic [3:0]        cv, cv_prev, cv_rise;
    logic              rd_prev, wr_prev;
    logic              rd_fall, rd_rise, wr_rise;
    logic              wr_blocked;
    logic [2:0]        rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] samples [8];

    assign cv      = {convst_D, convst_C, convst_B, convst_A};
    assign cv_rise = cv & ~cv_prev;
    assign rd_fall = ~read & rd_prev;
    assign rd_rise = read & ~rd_prev;
    assign wr_rise = write & ~wr_prev;
    assign busy    = (state == CONV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
            mask  <= mask_d;
        end
    end

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        mask_d     = mask;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (|cv_rise) begin
                    next_state = CONV;
                    cnt_d      = 8'(CONV_CYCLES - 1);
                    mask_d     = cv_rise;
                end
            end
            CONV: begin
                if (cnt == 8'd0) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Only pairs that saw a CONVST edge are refreshed; the others keep their last frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) samples[k] <= '0;
            frame_count <= '0;
        end else if (done) begin
            for (int k = 0; k < 8; k++)
                if (mask[k/2]) samples[k] <= sample_bus[k*DATA_W +: DATA_W];
            frame_count <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_prev <= '0;
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            cv_prev <= cv;
            rd_prev <= read;
            wr_prev <= write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_oe  <= 1'b0;
            db_out <= '0;
            rd_ptr <= '0;
        end else begin
            db_oe <= ~CS & ~read;
            if (rd_fall && !CS)
                db_out <= (state == IDLE) ? samples[rd_ptr] : '0;
            if (done)
                rd_ptr <= '0;
            else if (rd_rise && !CS && state == IDLE)
                rd_ptr <= rd_ptr + 3'd1;
        end
    end

    // A write whose low phase overlapped a selected read is dropped at its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_blocked <= 1'b0;
            wr_ptr     <= 1'b0;
            config_reg <= '0;
        end else begin
            if (wr_rise) begin
                wr_blocked <= 1'b0;
                if (!CS && !wr_blocked && read) begin
                    if (!wr_ptr) config_reg[31:16] <= db_in;
                    else         config_reg[15:0]  <= db_in;
                    wr_ptr <= ~wr_ptr;
                end
            end else if (!CS && !read && !write) begin
                wr_blocked <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ads8528_responder.md
Name: ads8528_responder

Overview:
- Clocked behavioural and synthesizable model of the ADS8528 parallel interface, seen from the ADC side.
- Used in simulation and FPGA loopback to exercise the ADC driver without the real part.
- Accepts config writes and per-pair CONVST pulses, asserts busy for a fixed conversion time, then returns eight 16-bit samples on successive RD strobes.

Parameters:
- CONV_CYCLES, 33: clocks busy stays high per conversion; legal range 1..255.
- DATA_W, 16: sample and bus width.

Ports:
- clk  in  1  system clock; all other inputs are synchronous to clk.
- rst  in  1  reset, asynchronous, active-high.
- convst_A  in  1  start conversion, pair A (rising-edge sensitive).
- convst_B  in  1  start conversion, pair B.
- convst_C  in  1  start conversion, pair C.
- convst_D  in  1  start conversion, pair D.
- CS  in  1  chip select, active low.
- read  in  1  RD strobe, active low.
- write  in  1  WR strobe, active low.
- db_in  in  DATA_W  bus value driven by host during writes.
- db_out  out  DATA_W  bus value driven by responder.
- db_oe  out  1  high when responder owns the bus.
- busy  out  1  conversion in progress.
- sample_bus  in  8*DATA_W  analogue stand-in; channel k = bits [16k+15:16k], order A0,A1,B0,B1,C0,C1,D0,D1.
- config_reg  out  32  {first config word, second config word}.
- frame_count  out  16  completed conversions, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset state: db_out=0, db_oe=0, busy=0, config_reg=0, frame_count=0, all sample registers=0, rd_ptr=0, wr_ptr=0, FSM=IDLE.
- Edge detection: each of convst_X, read and write has a registered previous value.
  - Rising edge = cur 1 & prev 0; falling edge = cur 0 & prev 1.
  - Reset initialises prev of convst_X to 0 and prev of read/write to 1.
- FSM states: IDLE, CONV.
- IDLE -> CONV: on any convst_X rising edge.
  - Capture mask = set of pairs with a rising edge in that same cycle.
  - busy=1 from the next cycle; counter loaded with CONV_CYCLES-1.
- CONV -> IDLE: when counter reaches 0.
  - In that cycle, latch sample_bus into only the masked pairs' registers; unmasked pairs retain old data.
  - busy=0 next cycle; rd_ptr<=0; frame_count++.
  - busy high duration = exactly CONV_CYCLES cycles.
- convst edges during CONV are ignored: no restart, no mask change.
- Read, responder drives bus:
  - db_oe = registered (CS==0 & read==0).
  - db_out updates the cycle after the read falling edge with CS low: db_out = sample[rd_ptr] in IDLE, 16'h0000 in CONV.
  - On read rising edge with CS low and FSM=IDLE: rd_ptr = (rd_ptr+1) mod 8, so the 9th read returns A0 again.
  - Reads in CONV never advance rd_ptr.
- Write, host drives bus:
  - On write rising edge with CS low, latch db_in.
  - wr_ptr=0 -> config_reg[31:16]; wr_ptr=1 -> config_reg[15:0]; wr_ptr toggles after each write.
  - Writes are accepted in any state and do not affect busy.
- Bus contention: read and write both low with CS low at the same time: write is ignored, read has priority, db_oe=1.
- CS high: read and write edges are ignored; db_oe=0 next cycle; rd_ptr and wr_ptr hold.
- Reset mid-conversion: busy drops immediately (async); captured data is discarded.

Test Plan:
- Reset, then CS low with write pulses of db_in=16'h1500 then 16'h0000 -> config_reg=32'h1500_0000, wr_ptr=0.
- sample_bus channel k = 16'h1000+k; all four convst rise together -> busy high exactly 33 cycles; then 8 reads return 1000..1007 in order, a 9th read returns 1000, frame_count=1.
- Second frame with sample_bus = 16'h2000+k and only convst_B rising -> reads return 1000,1001,2002,2003,1004..1007.
- convst_A pulsed again 10 cycles into busy -> busy still falls 33 cycles after the first edge; frame_count increments by 1 only.
- Read strobe during busy -> db_out=0, db_oe=1; after busy falls, the first read returns channel A0.
- Assert rst 5 cycles into a conversion -> busy=0 the same cycle; all samples read back 0; frame_count=0.
